// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - decode encodings, ALU control codes and the decode bundle type
package pipeline_pkg;

  localparam int GPR_AW = 5;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_ADDI = 4'b0010;
  localparam logic [3:0] ALU_J    = 4'b0011;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;

  typedef struct packed {
    logic [GPR_AW-1:0] operand_1;
    logic [GPR_AW-1:0] operand_2;
    logic [GPR_AW-1:0] dest;
    logic [3:0]        alu_control;
    logic              reg_write;
    logic [15:0]       immediate;
    logic [31:0]       jump_target;
    logic              illegal;
  } decode_bundle_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// rtl/gpr_scoreboard.sv - GPR busy bits with issue set, writeback/flush clear and two read ports
module gpr_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_GPR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [GPR_AW-1:0] set_addr,
  input  logic              wb_clr_en,
  input  logic [GPR_AW-1:0] wb_clr_addr,
  input  logic              fl_clr_en,
  input  logic [GPR_AW-1:0] fl_clr_addr,
  input  logic [GPR_AW-1:0] rd_addr_a,
  input  logic [GPR_AW-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NUM_GPR-1:0] busy_q;
  logic [NUM_GPR-1:0] busy_d;

  // Clears are applied first so a same-edge set of the same register survives.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr_en) busy_d[wb_clr_addr] = 1'b0;
    if (fl_clr_en) busy_d[fl_clr_addr] = 1'b0;
    if (set_en)    busy_d[set_addr]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a = busy_q[rd_addr_a];
  assign busy_b = busy_q[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage with RAW scoreboard; DECODE_ILLEGAL_TRAP_EN flags illegal encodings
module decode_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_GPR = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [4:0]      operand_1,
  output logic [4:0]      operand_2,
  output logic [31:0]     gpr_destination_address,
  output logic [3:0]      alu_control,
  output logic            reg_write,
  output logic [15:0]     immediate_value,
  output logic [31:0]     jump_target,
  output logic            ex_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic            flush
);

  decode_bundle_t bundle_q, bundle_d, dec;
  logic           ex_valid_q, ex_valid_d;
  logic           is_add, is_addi, is_j, is_nop;
  logic           busy_rs, busy_rt, hazard, transfer;
  logic           unused_pc;

  assign unused_pc = ^if_pc[XLEN-5:0];

  always_comb begin
    is_add  = (if_instr[31:26] == OPC_SPECIAL) && (if_instr[5:0] == FUNCT_ADD);
    is_addi = (if_instr[31:26] == OPC_ADDI);
    is_j    = (if_instr[31:26] == OPC_J);
    is_nop  = (if_instr == 32'h0);

    dec             = '0;
    dec.operand_1   = if_instr[25:21];
    dec.operand_2   = if_instr[20:16];
    dec.immediate   = if_instr[15:0];
    dec.jump_target = {if_pc[XLEN-1:XLEN-4], if_instr[25:0], 2'b00};
    if (is_add) begin
      dec.alu_control = ALU_ADD;
      dec.dest        = if_instr[15:11];
    end else if (is_addi) begin
      dec.alu_control = ALU_ADDI;
      dec.dest        = if_instr[20:16];
    end else if (is_j) begin
      dec.alu_control = ALU_J;
    end else if (!is_nop) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      dec.illegal = 1'b1;
`endif
    end
    dec.reg_write = (is_add || is_addi) && (dec.dest != '0);
  end

  assign hazard   = (busy_rs && (is_add || is_addi)) || (busy_rt && is_add);
  assign if_ready = !rst && !flush && (!ex_valid_q || ex_ready) && !hazard;
  assign transfer = if_valid && if_ready;

  always_comb begin
    bundle_d   = bundle_q;
    ex_valid_d = ex_valid_q;
    if (transfer) begin
      bundle_d   = dec;
      ex_valid_d = 1'b1;
    end else if (flush || ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      bundle_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      bundle_q   <= bundle_d;
    end
  end

  gpr_scoreboard #(.NUM_GPR(NUM_GPR)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (transfer && dec.reg_write),
    .set_addr    (dec.dest),
    .wb_clr_en   (wb_valid),
    .wb_clr_addr (wb_addr),
    .fl_clr_en   (flush && ex_valid_q && bundle_q.reg_write),
    .fl_clr_addr (bundle_q.dest),
    .rd_addr_a   (if_instr[25:21]),
    .rd_addr_b   (if_instr[20:16]),
    .busy_a      (busy_rs),
    .busy_b      (busy_rt)
  );

  assign ex_valid                = ex_valid_q;
  assign operand_1               = bundle_q.operand_1;
  assign operand_2               = bundle_q.operand_2;
  assign gpr_destination_address = {27'd0, bundle_q.dest};
  assign alu_control             = bundle_q.alu_control;
  assign reg_write               = bundle_q.reg_write;
  assign immediate_value         = bundle_q.immediate;
  assign jump_target             = bundle_q.jump_target;
  assign ex_illegal              = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed table and sequence bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, ex_valid, ex_ready;
  logic [31:0] if_instr, if_pc, gpr_destination_address, jump_target;
  logic [4:0]  operand_1, operand_2, wb_addr;
  logic [3:0]  alu_control;
  logic        reg_write, ex_illegal, wb_valid, flush;
  logic [15:0] immediate_value;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .operand_1(operand_1), .operand_2(operand_2),
    .gpr_destination_address(gpr_destination_address), .alu_control(alu_control),
    .reg_write(reg_write), .immediate_value(immediate_value), .jump_target(jump_target),
    .ex_illegal(ex_illegal), .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  op1;
    logic [4:0]  op2;
    logic [31:0] dest;
    logic [3:0]  alu;
    logic        rw;
    logic [15:0] imm;
    logic [31:0] jt;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"add3_1_2",  32'h00221820, 32'h00001000, 5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h1820, 32'h00886080, 1'b0};
    vecs[1] = '{"addi5_1",   32'h20251212, 32'h00001000, 5'd1, 5'd5, 32'd5, 4'b0010, 1'b1, 16'h1212, 32'h00944848, 1'b0};
    vecs[2] = '{"j",         32'h08000021, 32'hA0000000, 5'd0, 5'd0, 32'd0, 4'b0011, 1'b0, 16'h0021, 32'hA0000084, 1'b0};
    vecs[3] = '{"nop",       32'h00000000, 32'h00001000, 5'd0, 5'd0, 32'd0, 4'b0000, 1'b0, 16'h0000, 32'h00000000, 1'b0};
    vecs[4] = '{"add_rd0",   32'h00220020, 32'h00001000, 5'd1, 5'd2, 32'd0, 4'b0001, 1'b0, 16'h0020, 32'h00880080, 1'b0};
    vecs[5] = '{"addi_rt0",  32'h20200007, 32'h00001000, 5'd1, 5'd0, 32'd0, 4'b0010, 1'b0, 16'h0007, 32'h0080001C, 1'b0};
    vecs[6] = '{"ill_op3f",  32'hFC000000, 32'h00001000, 5'd0, 5'd0, 32'd0, 4'b0000, 1'b0, 16'h0000, 32'h00000000, ILL_EXP};
    vecs[7] = '{"ill_funct", 32'h00221822, 32'h00001000, 5'd1, 5'd2, 32'd0, 4'b0000, 1'b0, 16'h1822, 32'h00886088, ILL_EXP};

    rst = 1'b1; if_valid = 1'b1; if_instr = 32'h00221820; if_pc = 32'h00001000;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; flush = 1'b0;
    step();
    step();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_op1", {27'd0, operand_1}, 32'd0);
    chk("rst_dest", gpr_destination_address, 32'd0);
    chk("rst_alu", {28'd0, alu_control}, 32'd0);
    chk("rst_rw", {31'd0, reg_write}, 32'd0);
    chk("rst_imm", {16'd0, immediate_value}, 32'd0);
    chk("rst_jt", jump_target, 32'd0);
    chk("rst_ill", {31'd0, ex_illegal}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if_valid = 1'b1; if_instr = vecs[i].instr; if_pc = vecs[i].pc; ex_ready = 1'b1;
      #1;
      chk({vecs[i].name, "_if_ready"}, {31'd0, if_ready}, 32'd1);
      step();
      if_valid = 1'b0;
      chk({vecs[i].name, "_ex_valid"}, {31'd0, ex_valid}, 32'd1);
      chk({vecs[i].name, "_op1"}, {27'd0, operand_1}, {27'd0, vecs[i].op1});
      chk({vecs[i].name, "_op2"}, {27'd0, operand_2}, {27'd0, vecs[i].op2});
      chk({vecs[i].name, "_dest"}, gpr_destination_address, vecs[i].dest);
      chk({vecs[i].name, "_alu"}, {28'd0, alu_control}, {28'd0, vecs[i].alu});
      chk({vecs[i].name, "_rw"}, {31'd0, reg_write}, {31'd0, vecs[i].rw});
      chk({vecs[i].name, "_imm"}, {16'd0, immediate_value}, {16'd0, vecs[i].imm});
      chk({vecs[i].name, "_jt"}, jump_target, vecs[i].jt);
      chk({vecs[i].name, "_ill"}, {31'd0, ex_illegal}, {31'd0, vecs[i].ill});
      wb_valid = 1'b1; wb_addr = vecs[i].dest[4:0];
      step();
      wb_valid = 1'b0;
      chk({vecs[i].name, "_drain"}, {31'd0, ex_valid}, 32'd0);
    end

    // RAW hazard on $5 held until writeback, released the following cycle.
    if_pc = 32'h00001000; if_valid = 1'b1; if_instr = 32'h20251212;
    step();
    if_instr = 32'h00A23020;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("haz_stall", {31'd0, if_ready}, 32'd0);
      step();
    end
    chk("haz_first_drained", {31'd0, ex_valid}, 32'd0);
    wb_valid = 1'b1; wb_addr = 5'd5;
    #1;
    chk("haz_wb_cycle", {31'd0, if_ready}, 32'd0);
    step();
    wb_valid = 1'b0;
    chk("haz_release", {31'd0, if_ready}, 32'd1);
    step();
    if_valid = 1'b0;
    chk("haz_issue_valid", {31'd0, ex_valid}, 32'd1);
    chk("haz_issue_op1", {27'd0, operand_1}, 32'd5);
    chk("haz_issue_dest", gpr_destination_address, 32'd6);
    wb_valid = 1'b1; wb_addr = 5'd6;
    step();
    wb_valid = 1'b0;

    // Back-pressure holds the bundle, then flush drops it and frees $3.
    if_valid = 1'b1; if_instr = 32'h00221820; ex_ready = 1'b0;
    step();
    if_instr = 32'h00000000;
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", {31'd0, ex_valid}, 32'd1);
      chk("stall_op1", {27'd0, operand_1}, 32'd1);
      chk("stall_dest", gpr_destination_address, 32'd3);
      chk("stall_alu", {28'd0, alu_control}, 32'd1);
      chk("stall_if_ready", {31'd0, if_ready}, 32'd0);
      step();
    end
    flush = 1'b1;
    #1;
    chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    if_instr = 32'h00602020;
    #1;
    chk("flush_busy3_clear", {31'd0, if_ready}, 32'd1);
    ex_ready = 1'b1;
    step();
    if_valid = 1'b0;
    chk("dep_issue_dest", gpr_destination_address, 32'd4);
    wb_valid = 1'b1; wb_addr = 5'd4;
    step();
    wb_valid = 1'b0;

    // Same-edge issue and writeback of $7: the issue's set must survive.
    if_valid = 1'b1; if_instr = 32'h20270001; wb_valid = 1'b1; wb_addr = 5'd7;
    step();
    wb_valid = 1'b0; if_instr = 32'h00E04020;
    #1;
    chk("set_wins_stall", {31'd0, if_ready}, 32'd0);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    chk("set_wins_release", {31'd0, if_ready}, 32'd1);

    // Full-throughput back-to-back issue.
    if_instr = 32'h08000021; if_pc = 32'hA0000000;
    step();
    chk("b2b_first_alu", {28'd0, alu_control}, 32'd3);
    if_instr = 32'h00221820;
    #1;
    chk("b2b_ready", {31'd0, if_ready}, 32'd1);
    step();
    if_valid = 1'b0;
    chk("b2b_valid", {31'd0, ex_valid}, 32'd1);
    chk("b2b_second_alu", {28'd0, alu_control}, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction decode stage; producer end of the decode→execute interface. Accepts fetched 32-bit MIPS-style instruction words and emits the operand register addresses, destination, ALU control, immediate and jump target that the execute stage consumes. Owns a GPR busy scoreboard and stalls fetch on read-after-write hazards until writeback clears the producer. Sits between fetch and execute, with one registered output slot.

Parameters:
XLEN, 32, datapath/PC width
NUM_GPR, 32, number of GPRs; scoreboard depth; address width = 5

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch presents instruction
if_ready  out  1  decode accepts instruction this cycle
if_instr  in  32  instruction word
if_pc  in  32  PC of if_instr
ex_valid  out  1  decoded bundle valid
ex_ready  in  1  execute consumes bundle
operand_1  out  5  rs address
operand_2  out  5  rt address
gpr_destination_address  out  32  destination GPR, zero-extended
alu_control  out  4  0000 NOP, 0001 ADD, 0010 ADDI, 0011 J
reg_write  out  1  instruction writes a GPR
immediate_value  out  16  instr[15:0]
jump_target  out  32  {if_pc[31:28], instr[25:0], 2'b00}
ex_illegal  out  1  unrecognised encoding (see Optional Feature)
wb_valid  in  1  writeback retires a GPR write
wb_addr  in  5  GPR retired
flush  in  1  drop in-flight bundle

Behaviour:
- Clock clk; reset rst is synchronous and active-high. Reset: ex_valid=0, all bundle outputs 0, ex_illegal=0, scoreboard all clear. Reset wins over every other event.
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
- Decode: opcode 0x00 & funct 0x20 → ADD, dest=rd, reg_write=1; opcode 0x08 → ADDI, dest=rt, reg_write=1; opcode 0x02 → J, reg_write=0; word 0x00000000 → NOP, reg_write=0. Anything else → illegal handling.
- Destination 0 forces reg_write=0.
- Hazard: rs busy (ADD, ADDI) or rt busy (ADD only). GPR 0 never busy. J/NOP never hazard.
- if_ready = !rst && !flush && (!ex_valid || ex_ready) && !hazard. Combinational from if_instr, scoreboard, ex_valid, ex_ready.
- Transfer on if_valid && if_ready: bundle registered, ex_valid=1 next cycle (latency 1). If reg_write, busy[dest] set at the same edge.
- ex_valid && ex_ready with no new transfer: ex_valid→0 next cycle. Back-to-back transfers at full throughput allowed.
- ex_valid && !ex_ready: every output held stable.
- wb_valid clears busy[wb_addr]; clearing a non-busy entry has no effect. Same-edge set and clear of the same register: set wins. A hazard resolved by writeback releases if_ready the cycle after wb_valid (scoreboard registered, no bypass).
- flush: ex_valid→0; if the dropped bundle had reg_write, its busy bit is cleared (unless wb set/clear rules say otherwise—clear). No transfer during flush.
- Scoreboard state is only set by issue and cleared by writeback, flush or reset.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN. Defined: an illegal encoding is issued as a bundle with alu_control=0000, reg_write=0, ex_illegal=1 (held with the bundle). Undefined: an illegal encoding is issued as a silent NOP; ex_illegal is tied to 0. The port exists in both builds.

Decomposition:
- pipeline_pkg: alu_control localparams (ALU_NOP/ADD/ADDI/J), opcode and funct constants, packed struct for the decode bundle, GPR address width.
- Sub-module gpr_scoreboard: NUM_GPR busy bits, set/clear ports, two read ports (rs, rt); set-wins priority inside it.

Test Plan:
- Assert rst for 2 cycles with if_valid=1 → ex_valid=0, if_ready=0, all outputs 0; scoreboard empty (issue dependent ADD immediately after reset, no stall).
- if_instr=0x00221820 (add $3,$1,$2) → next cycle ex_valid=1, operand_1=1, operand_2=2, gpr_destination_address=3, alu_control=0001, reg_write=1.
- if_instr=0x20251212 (addi $5,$1,0x1212) then 0x00A23020 (add $6,$5,$2), ex_ready=1 → second held with if_ready=0 until wb_valid=1, wb_addr=5; it issues one cycle after writeback.
- if_pc=0xA0000000, if_instr=0x08000021 (j) → alu_control=0011, jump_target=0xA0000084, reg_write=0, no busy bit set.
- Hold ex_ready=0 for 3 cycles after an ADD issue → outputs stable, if_ready=0; then assert flush → ex_valid=0 and busy[3] cleared.
- if_instr=0xFC000000 → with DECODE_ILLEGAL_TRAP_EN, ex_illegal=1 and alu_control=0000; without it, ex_illegal=0 and a NOP is issued.
